// File: rtl/control_subcmd_readarea_pkg.sv
// Shared panel geometry and readarea sub-command types.
package params_pkg;

   localparam int unsigned PIXEL_HEIGHT    = 4;
   localparam int unsigned BYTES_PER_PIXEL = 2;

   localparam int unsigned ROW_BITS    = (PIXEL_HEIGHT > 1) ? $clog2(PIXEL_HEIGHT) : 1;
   localparam int unsigned HEIGHT_BITS = $clog2(PIXEL_HEIGHT + 1);
   localparam int unsigned PIXEL_BITS  = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;

   // Cycles from ram_read_enable to valid ram_data_in.
   localparam int unsigned READAREA_RAM_LATENCY = 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      CAPTURE = 3'd2,
      HOLD    = 3'd3,
      DONE    = 3'd4
   } readarea_state_t;

endpackage

// File: rtl/control_subcmd_readarea_scan.sv
// Clipped rectangle scanner: row/column/pixel down-counters walking a region
// from its bottom-right byte back to its top-left byte.
module rect_scan_counter
   import params_pkg::*;
#(
   parameter  int unsigned PIXEL_WIDTH = 64,
   localparam int unsigned CB = (PIXEL_WIDTH > 1) ? $clog2(PIXEL_WIDTH) : 1,
   localparam int unsigned WB = $clog2(PIXEL_WIDTH + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load,
   input  logic                   step,
   input  logic [CB-1:0]          x1,
   input  logic [ROW_BITS-1:0]    y1,
   input  logic [WB-1:0]          width,
   input  logic [HEIGHT_BITS-1:0] height,
   output logic [ROW_BITS-1:0]    row,
   output logic [CB-1:0]          column,
   output logic [PIXEL_BITS-1:0]  pixel,
   output logic                   last_c
);

   logic [CB-1:0]       x1_q;
   logic [ROW_BITS-1:0] y1_q;
   logic [CB-1:0]       last_col_q;
   logic [CB+1:0]       col_end;
   logic [ROW_BITS+1:0] row_end;
   logic [CB-1:0]       last_col_c;
   logic [ROW_BITS-1:0] last_row_c;

   // Exclusive region end computed two bits wide, then clipped to the panel.
   always_comb begin
      col_end    = (CB+2)'(x1) + (CB+2)'(width);
      row_end    = (ROW_BITS+2)'(y1) + (ROW_BITS+2)'(height);
      last_col_c = x1;
      last_row_c = y1;
      if (width != '0) begin
         if (col_end > (CB+2)'(PIXEL_WIDTH)) last_col_c = CB'(PIXEL_WIDTH - 1);
         else                                last_col_c = CB'(col_end - (CB+2)'(1));
      end
      if (height != '0) begin
         if (row_end > (ROW_BITS+2)'(PIXEL_HEIGHT)) last_row_c = ROW_BITS'(PIXEL_HEIGHT - 1);
         else                                       last_row_c = ROW_BITS'(row_end - (ROW_BITS+2)'(1));
      end
   end

   assign last_c = (row == y1_q) && (column == x1_q) && (pixel == '0);

   // Pixel, then column, then row; each stops at its lower limit.
   always_ff @(posedge clk) begin
      if (reset) begin
         row        <= '0;
         column     <= '0;
         pixel      <= '0;
         x1_q       <= '0;
         y1_q       <= '0;
         last_col_q <= '0;
      end else if (load) begin
         x1_q       <= x1;
         y1_q       <= y1;
         last_col_q <= last_col_c;
         row        <= last_row_c;
         column     <= last_col_c;
         pixel      <= PIXEL_BITS'(BYTES_PER_PIXEL - 1);
      end else if (step) begin
         if (pixel != '0) begin
            pixel <= pixel - PIXEL_BITS'(1);
         end else if (column != x1_q) begin
            column <= column - CB'(1);
            pixel  <= PIXEL_BITS'(BYTES_PER_PIXEL - 1);
         end else if (row != y1_q) begin
            row    <= row - ROW_BITS'(1);
            column <= last_col_q;
            pixel  <= PIXEL_BITS'(BYTES_PER_PIXEL - 1);
         end
      end
   end

endmodule

// File: rtl/control_subcmd_readarea.sv
// Readarea sub-command: reads a clipped framebuffer rectangle and streams it
// out byte by byte over valid/ready, in the same order a fill writes it.
module control_subcmd_readarea
   import params_pkg::*;
#(
   parameter  int unsigned PIXEL_WIDTH = 64,
   localparam int unsigned CB = (PIXEL_WIDTH > 1) ? $clog2(PIXEL_WIDTH) : 1,
   localparam int unsigned WB = $clog2(PIXEL_WIDTH + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   ack,
   input  logic [CB-1:0]          x1,
   input  logic [ROW_BITS-1:0]    y1,
   input  logic [WB-1:0]          width,
   input  logic [HEIGHT_BITS-1:0] height,
   output logic [ROW_BITS-1:0]    row,
   output logic [CB-1:0]          column,
   output logic [PIXEL_BITS-1:0]  pixel,
   output logic                   ram_read_enable,
   output logic                   ram_access_start,
   input  logic [7:0]             ram_data_in,
   output logic [7:0]             data_out,
   output logic                   data_valid,
   input  logic                   data_ready,
   output logic                   done
);

   readarea_state_t state, next_state;
   logic enable_q;
   logic start_c;
   logic load_c;
   logic step_c;
   logic last_c;

   // A new command needs a rising edge of enable.
   assign start_c = enable && !enable_q;

   rect_scan_counter #(.PIXEL_WIDTH(PIXEL_WIDTH)) u_scan (
      .clk    (clk),
      .reset  (reset),
      .load   (load_c),
      .step   (step_c),
      .x1     (x1),
      .y1     (y1),
      .width  (width),
      .height (height),
      .row    (row),
      .column (column),
      .pixel  (pixel),
      .last_c (last_c)
   );

   always_comb begin
      next_state = state;
      load_c     = 1'b0;
      step_c     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start_c) begin
               load_c     = 1'b1;
               next_state = (width == '0 || height == '0) ? DONE : ISSUE;
            end
         end
         ISSUE:   next_state = enable ? CAPTURE : IDLE;
         CAPTURE: next_state = enable ? HOLD : IDLE;
         HOLD: begin
            if (!enable) begin
               next_state = IDLE;
            end else if (data_ready) begin
               if (last_c) begin
                  next_state = DONE;
               end else begin
                  step_c     = 1'b1;
                  next_state = ISSUE;
               end
            end
         end
         DONE:    if (ack) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs are registered from the upcoming state so they align with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         enable_q         <= 1'b0;
         ram_read_enable  <= 1'b0;
         ram_access_start <= 1'b0;
         data_out         <= '0;
         data_valid       <= 1'b0;
         done             <= 1'b0;
      end else begin
         state            <= next_state;
         enable_q         <= enable;
         ram_read_enable  <= (next_state == ISSUE);
         ram_access_start <= (state == IDLE) && (next_state == ISSUE);
         data_valid       <= (next_state == HOLD);
         done             <= (next_state == DONE);
         if (state == CAPTURE && next_state == HOLD) data_out <= ram_data_in;
      end
   end

endmodule

// File: tb/tb_control_subcmd_readarea.sv
// Bench for control_subcmd_readarea on a 4x4 panel with 2 bytes per pixel.
module tb_control_subcmd_readarea;
   import params_pkg::*;

   localparam int unsigned PW = 4;

   logic       clk = 1'b0;
   logic       reset, enable, ack;
   logic [1:0] x1, y1;
   logic [2:0] width, height;
   logic [1:0] row, column;
   logic [0:0] pixel;
   logic       ram_read_enable, ram_access_start;
   logic [7:0] ram_data_in = 8'h00;
   logic [7:0] data_out;
   logic       data_valid, data_ready, done;

   always #5 clk = ~clk;

   control_subcmd_readarea #(.PIXEL_WIDTH(PW)) dut (
      .clk(clk), .reset(reset), .enable(enable), .ack(ack),
      .x1(x1), .y1(y1), .width(width), .height(height),
      .row(row), .column(column), .pixel(pixel),
      .ram_read_enable(ram_read_enable), .ram_access_start(ram_access_start),
      .ram_data_in(ram_data_in), .data_out(data_out), .data_valid(data_valid),
      .data_ready(data_ready), .done(done)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // RAM model: byte at {row,col,px} is row<<4 | col<<1 | px.
   logic [7:0] mem [32];
   initial for (int i = 0; i < 32; i++) mem[i] = 8'(((i >> 3) << 4) | (((i >> 1) & 3) << 1) | (i & 1));
   always @(posedge clk) if (ram_read_enable) ram_data_in <= mem[{row, column, pixel}];

   logic [7:0] got[$];
   int reads = 0, starts = 0, bad_addr = 0;
   int lo_c = 0, hi_c = 3, lo_r = 0, hi_r = 3;
   always @(posedge clk) begin
      if (!reset) begin
         if (data_valid && data_ready) got.push_back(data_out);
         if (ram_read_enable) begin
            reads++;
            if (int'(column) < lo_c || int'(column) > hi_c || int'(row) < lo_r || int'(row) > hi_r)
               bad_addr++;
         end
         if (ram_access_start) starts++;
      end
   end

   // Backpressure driver: holds data_ready low for 5 cycles on byte index 3.
   logic       stall_on = 1'b0;
   int         stall_cnt = 0;
   logic [7:0] held = 8'h00;
   always @(negedge clk) begin
      if (stall_on && data_valid && got.size() == 3 && stall_cnt < 5) begin
         if (stall_cnt == 0) held = data_out;
         else begin
            check("stall_data_stable", int'(data_out), int'(held));
            check("stall_valid_stable", int'(data_valid), 1);
         end
         data_ready = 1'b0;
         stall_cnt++;
      end else begin
         data_ready = 1'b1;
      end
   end

   task automatic run_cmd(input int x, input int y, input int w, input int h, input int extra);
      logic [7:0] exp_q[$];
      int lc, lr, cyc, reads_after;
      lc = (x + w - 1 > 3) ? 3 : x + w - 1;
      lr = (y + h - 1 > 3) ? 3 : y + h - 1;
      if (w > 0 && h > 0)
         for (int r = lr; r >= y; r--)
            for (int c = lc; c >= x; c--)
               for (int p = 1; p >= 0; p--)
                  exp_q.push_back(8'((r << 4) | (c << 1) | p));
      @(negedge clk);
      got.delete();
      reads = 0; starts = 0; bad_addr = 0;
      lo_c = x; hi_c = lc; lo_r = y; hi_r = lr;
      x1 = 2'(x); y1 = 2'(y); width = 3'(w); height = 3'(h);
      enable = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!done && cyc < 200);
      check("done_seen", int'(done), 1);
      check("latency_in_budget", int'(cyc <= exp_q.size() * 3 + 2 + extra), 1);
      check("byte_count", got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         check($sformatf("byte[%0d]", i), int'(got[i]), int'(exp_q[i]));
      check("read_strobes", reads, exp_q.size());
      check("access_start_pulses", starts, (exp_q.size() > 0) ? 1 : 0);
      check("addr_in_region", bad_addr, 0);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check("done_after_ack", int'(done), 0);
      check("state_after_ack", int'(dut.state), 0);
      reads_after = reads;
      repeat (3) @(negedge clk);
      check("no_restart_without_edge", int'(dut.state), 0);
      check("no_read_without_edge", reads, reads_after);
      enable = 1'b0;
      @(negedge clk);
   endtask

   typedef struct {
      int         x, y, w, h, count;
      logic [7:0] first, last;
   } vec_t;
   vec_t vecs[7];

   initial begin
      int n;
      vecs[0] = '{x:0, y:0, w:4, h:4, count:32, first:8'h37, last:8'h00};
      vecs[1] = '{x:1, y:2, w:2, h:1, count:4,  first:8'h25, last:8'h22};
      vecs[2] = '{x:3, y:0, w:4, h:4, count:8,  first:8'h37, last:8'h06};
      vecs[3] = '{x:0, y:1, w:1, h:2, count:4,  first:8'h21, last:8'h10};
      vecs[4] = '{x:2, y:1, w:0, h:3, count:0,  first:8'h00, last:8'h00};
      vecs[5] = '{x:1, y:1, w:2, h:0, count:0,  first:8'h00, last:8'h00};
      vecs[6] = '{x:2, y:3, w:3, h:3, count:4,  first:8'h37, last:8'h34};

      reset = 1'b1; enable = 1'b0; ack = 1'b0;
      x1 = '0; y1 = '0; width = '0; height = '0;
      repeat (2) @(negedge clk);
      check("reset_state", int'(dut.state), 0);
      check("reset_outputs", int'({row, column, pixel, data_out, ram_read_enable,
                                   ram_access_start, data_valid, done}), 0);
      reset = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) begin
         run_cmd(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, 0);
         check($sformatf("vec%0d_count", i), got.size(), vecs[i].count);
         if (vecs[i].count > 0 && got.size() > 0) begin
            check($sformatf("vec%0d_first", i), int'(got[0]), int'(vecs[i].first));
            check($sformatf("vec%0d_last", i), int'(got[got.size()-1]), int'(vecs[i].last));
         end
      end

      // Backpressure on byte 3 of a full read.
      stall_cnt = 0;
      stall_on  = 1'b1;
      run_cmd(0, 0, 4, 4, 5);
      stall_on  = 1'b0;
      check("stall_cycles", stall_cnt, 5);

      // Abort by dropping enable mid-stream.
      got.delete();
      x1 = 2'd0; y1 = 2'd0; width = 3'd4; height = 3'd4;
      enable = 1'b1;
      n = 0;
      while (got.size() < 2 && n < 50) begin @(negedge clk); n++; end
      check("abort_reached_byte2", int'(got.size() >= 2), 1);
      enable = 1'b0;
      @(negedge clk);
      check("abort_state", int'(dut.state), 0);
      check("abort_valid", int'(data_valid), 0);
      repeat (3) @(negedge clk);
      check("abort_no_done", int'(done), 0);

      // Reset after byte 5, then a clean full read.
      got.delete();
      enable = 1'b1;
      n = 0;
      while (got.size() < 5 && n < 50) begin @(negedge clk); n++; end
      check("reset_reached_byte5", int'(got.size() >= 5), 1);
      reset = 1'b1;
      @(negedge clk);
      check("midreset_outputs", int'({row, column, pixel, data_out, ram_read_enable,
                                      ram_access_start, data_valid, done}), 0);
      check("midreset_state", int'(dut.state), 0);
      reset = 1'b0; enable = 1'b0;
      @(negedge clk);
      run_cmd(0, 0, 4, 4, 0);
      check("post_reset_count", got.size(), 32);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
